adder_share_arb: RTL



---
 rtl/adder_share_arb_if.sv | 32 +++
 rtl/adder_share_arb.sv | 137 +++++++++++++
 2 files changed

// File: rtl/adder_share_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arb_if
//  Description : Requester/response bundle for the shared-adder arbiter.
//                The slave modport is the arbiter's view, the master modport
//                belongs to the requesters and the response consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface adder_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0]    req_v;
    logic [NREQ*23-1:0] req_x;
    logic [NREQ*23-1:0] req_y;
    logic [NREQ-1:0]    req_rdy;
    logic               rsp_v;
    logic [IDW-1:0]     rsp_id;
    logic [23:0]        rsp_s;
    logic               rsp_rdy;

    modport slave (
        input  req_v, req_x, req_y, rsp_rdy,
        output req_rdy, rsp_v, rsp_id, rsp_s
    );

    modport master (
        output req_v, req_x, req_y, rsp_rdy,
        input  req_rdy, rsp_v, rsp_id, rsp_s
    );
endinterface
`default_nettype wire

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arb
//  Description : Round-robin arbiter sharing one 23+23-bit carry-select adder
//                among NREQ requesters. One grant per cycle, registered
//                24-bit sum tagged with the requester ID, single response
//                channel with backpressure.
//                Optional macro ADDER_SHARE_ARB_PERF_CNT_EN adds saturating
//                per-requester grant counters and a stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    adder_share_arb_if.slave        bus
`ifdef ADDER_SHARE_ARB_PERF_CNT_EN
    ,
    output logic [NREQ*16-1:0]      o_gnt_cnt,
    output logic [15:0]             o_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [23:0]     r_rsp_s;

    logic            w_acc;
    logic            w_found;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0] w_req_rdy;
    logic [22:0]     w_x;
    logic [22:0]     w_y;
    logic [12:0]     w_lo;
    logic [11:0]     w_hi0;
    logic [11:0]     w_hi1;
    logic [23:0]     w_sum;

    // The output register can take a new result when empty or being drained.
    assign w_acc = (r_state == ST_EMPTY) || bus.rsp_rdy;

    // Round-robin search: walk offsets from the far end so the offset closest
    // to the pointer is the last (winning) assignment.
    always_comb begin
        int v_idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        v_idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            if (bus.req_v[v_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(v_idx);
            end
        end
    end

    // Ready is held off entirely while in reset or while the response is stuck.
    assign w_req_rdy = (w_acc && w_found && !rst) ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    // Operand mux feeding the single shared adder.
    assign w_x = bus.req_x[int'(w_gnt_idx)*23 +: 23];
    assign w_y = bus.req_y[int'(w_gnt_idx)*23 +: 23];

    // Carry-select adder: low 12 bits ripple, upper 11 bits are precomputed
    // for both carry-in values and selected by the low-half carry.
    assign w_lo  = {1'b0, w_x[11:0]}  + {1'b0, w_y[11:0]};
    assign w_hi0 = {1'b0, w_x[22:12]} + {1'b0, w_y[22:12]};
    assign w_hi1 = {1'b0, w_x[22:12]} + {1'b0, w_y[22:12]} + 12'd1;
    assign w_sum = {(w_lo[12] ? w_hi1 : w_hi0), w_lo[11:0]};

    // Output-stage FSM, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_ptr    <= '0;
            r_rsp_id <= '0;
            r_rsp_s  <= '0;
        end else if (w_acc) begin
            if (w_found) begin
                r_state  <= ST_FULL;
                r_rsp_id <= w_gnt_idx;
                r_rsp_s  <= w_sum;
                r_ptr    <= w_ptr_nxt;
            end else begin
                r_state  <= ST_EMPTY;
            end
        end
    end

    assign bus.req_rdy = w_req_rdy;
    assign bus.rsp_v   = (r_state == ST_FULL);
    assign bus.rsp_id  = r_rsp_id;
    assign bus.rsp_s   = r_rsp_s;

`ifdef ADDER_SHARE_ARB_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt_cnt
            logic [15:0] r_cnt;
            // Saturating count of handshakes for this requester.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_req_rdy[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign o_gnt_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate

    // Saturating count of cycles the response sits unconsumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_FULL) && !bus.rsp_rdy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
